// File: rtl/mask_centroid_pkg.sv
// Shared types and width helpers for the mask centroid block.
package mask_centroid_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } state_t;

  function automatic int xw_f(input int hres);
    return $clog2(hres);
  endfunction

  function automatic int yw_f(input int vres);
    return $clog2(vres);
  endfunction

  function automatic int cw_f(input int hres, input int vres);
    return $clog2(hres * vres + 1);
  endfunction

  function automatic int sw_f(input int hres, input int vres);
    return $clog2(hres * hres * vres) + 1;
  endfunction

endpackage

// File: rtl/mask_centroid_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, DW-cycle latency.
module seq_divider #(
  parameter  int DW = 26,
  parameter  int VW = 16,
  parameter  int QW = DW,
  localparam int NW = $clog2(DW + 1)
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          start_in,
  input  logic [DW-1:0] dividend_in,
  input  logic [VW-1:0] divisor_in,
  output logic          busy_out,
  output logic          done_out,
  output logic [QW-1:0] quotient_out
);

  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [VW:0]   trial;

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    trial  = {rem_q, quo_q[DW-1]};
    if (start_in) begin
      quo_d  = dividend_in;
      rem_d  = '0;
      dvs_d  = divisor_in;
      cnt_d  = NW'(DW);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (trial >= {1'b0, dvs_q}) begin
        rem_d = VW'(trial - {1'b0, dvs_q});
        quo_d = {quo_q[DW-2:0], 1'b1};
      end else begin
        rem_d = trial[VW-1:0];
        quo_d = {quo_q[DW-2:0], 1'b0};
      end
      cnt_d  = cnt_q - NW'(1);
      busy_d = (cnt_q != NW'(1));
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // high in the cycle whose closing edge makes the quotient final
  assign done_out     = busy_q && (cnt_q == NW'(1));
  assign busy_out     = busy_q;
  assign quotient_out = quo_q[QW-1:0];

endmodule

// File: rtl/mask_centroid.sv
// Per-frame centroid of a binned mask stream with sequential division.
// Optional bounding box via MASK_CENTROID_BBOX_EN.
module mask_centroid
  import mask_centroid_pkg::*;
#(
  parameter  int HRES      = 320,
  parameter  int VRES      = 180,
  parameter  int MIN_COUNT = 4,
  localparam int XW        = xw_f(HRES),
  localparam int YW        = yw_f(VRES),
  localparam int CW        = cw_f(HRES, VRES),
  localparam int SW        = sw_f(HRES, VRES)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [XW-1:0]         hcount_in,
  input  logic [YW-1:0]         vcount_in,
  input  logic                  pixel_data_in,
  input  logic                  data_valid_in,
  output logic [XW-1:0]         x_out,
  output logic [YW-1:0]         y_out,
  output logic [CW-1:0]         count_out,
  output logic                  found_out,
  output logic                  centroid_valid_out,
  output logic                  overrun_out,
  output logic [2*(XW+YW)-1:0]  bbox_out
);

  localparam logic [CW-1:0] MINC = CW'(MIN_COUNT);

  state_t        state_q;
  logic          primed_q;
  logic [CW-1:0] cnt_q, cnt_d, cnt_snap_q;
  logic [SW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [CW-1:0] count_q;
  logic          found_q, valid_q, ovr_q;

  logic          fs, hit, snap, start;
  logic          dx_busy, dy_busy, dx_done, dy_done;
  logic [XW-1:0] qx;
  logic [YW-1:0] qy;

  assign fs    = data_valid_in && hcount_in == '0
              && vcount_in == '0;
  assign hit   = data_valid_in && pixel_data_in;
  assign snap  = fs && primed_q && (state_q == IDLE)
              && !(dx_busy || dy_busy);
  assign start = snap && (cnt_q != '0);

  // a frame-start beat sits at (0,0), so its sums contribution is zero
  always_comb begin
    cnt_d = cnt_q;
    sx_d  = sx_q;
    sy_d  = sy_q;
    if (fs) begin
      cnt_d = CW'(pixel_data_in);
      sx_d  = '0;
      sy_d  = '0;
    end else if (hit) begin
      cnt_d = cnt_q + CW'(1);
      sx_d  = sx_q + SW'(hcount_in);
      sy_d  = sy_q + SW'(vcount_in);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
    end
  end

  seq_divider #(.DW(SW), .VW(CW), .QW(XW)) u_div_x (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .start_in     (start),
    .dividend_in  (sx_q),
    .divisor_in   (cnt_q),
    .busy_out     (dx_busy),
    .done_out     (dx_done),
    .quotient_out (qx)
  );

  seq_divider #(.DW(SW), .VW(CW), .QW(YW)) u_div_y (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .start_in     (start),
    .dividend_in  (sy_q),
    .divisor_in   (cnt_q),
    .busy_out     (dy_busy),
    .done_out     (dy_done),
    .quotient_out (qy)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      primed_q   <= 1'b0;
      cnt_snap_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      count_q    <= '0;
      found_q    <= 1'b0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ovr_q   <= fs && primed_q && (state_q != IDLE);
      if (fs) primed_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (snap) begin
            cnt_snap_q <= cnt_q;
            state_q    <= (cnt_q == '0) ? DONE : DIVIDE;
          end
        end
        DIVIDE: begin
          if (dx_done && dy_done) state_q <= DONE;
        end
        DONE: begin
          valid_q <= 1'b1;
          count_q <= cnt_snap_q;
          found_q <= cnt_snap_q >= MINC;
          if (cnt_snap_q != '0) begin
            x_q <= qx;
            y_q <= qy;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x_out              = x_q;
  assign y_out              = y_q;
  assign count_out          = count_q;
  assign found_out          = found_q;
  assign centroid_valid_out = valid_q;
  assign overrun_out        = ovr_q;

`ifdef MASK_CENTROID_BBOX_EN
  localparam int BW = 2 * (XW + YW);

  logic [XW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [YW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic [BW-1:0] bsnap_q, bbox_q;

  // an empty frame leaves min above max; masked on output by count==0
  always_comb begin
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    if (fs) begin
      xmin_d = pixel_data_in ? '0 : '1;
      xmax_d = '0;
      ymin_d = pixel_data_in ? '0 : '1;
      ymax_d = '0;
    end else if (hit) begin
      if (hcount_in < xmin_q) xmin_d = hcount_in;
      if (hcount_in > xmax_q) xmax_d = hcount_in;
      if (vcount_in < ymin_q) ymin_d = vcount_in;
      if (vcount_in > ymax_q) ymax_d = vcount_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      xmin_q  <= '1;
      xmax_q  <= '0;
      ymin_q  <= '1;
      ymax_q  <= '0;
      bsnap_q <= '0;
      bbox_q  <= '0;
    end else begin
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
      if (snap)
        bsnap_q <= {xmin_q, xmax_q, ymin_q, ymax_q};
      if (state_q == DONE)
        bbox_q <= (cnt_snap_q == '0) ? '0 : bsnap_q;
    end
  end

  assign bbox_out = bbox_q;
`else
  assign bbox_out = '0;
`endif

endmodule

// File: tb/tb_mask_centroid.sv
// Directed self-checking bench for mask_centroid.
// Define MASK_CENTROID_BBOX_EN to check the bounding box outputs.
module tb_mask_centroid;

  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 16;
  localparam int SW = 26;
  localparam int BW = 34;

  logic          clk;
  logic          rst_n;
  logic [XW-1:0] hc;
  logic [YW-1:0] vc;
  logic          px;
  logic          dv;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic [CW-1:0] count_out;
  logic          found;
  logic          cvalid;
  logic          ovr;
  logic [BW-1:0] bbox;

  int total = 0;
  int bad   = 0;

  mask_centroid dut (
    .clk_in             (clk),
    .rst_n_in           (rst_n),
    .hcount_in          (hc),
    .vcount_in          (vc),
    .pixel_data_in      (px),
    .data_valid_in      (dv),
    .x_out              (x_out),
    .y_out              (y_out),
    .count_out          (count_out),
    .found_out          (found),
    .centroid_valid_out (cvalid),
    .overrun_out        (ovr),
    .bbox_out           (bbox)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic beat(input int h, input int v,
                      input bit p, input bit d = 1'b1);
    hc = XW'(h);
    vc = YW'(v);
    px = p;
    dv = d;
    @(posedge clk);
    #1;
    dv = 1'b0;
    px = 1'b0;
  endtask

  // edges counted from the frame-start edge; valid seen after edge k
  // means it is high in the cycle that closes at edge k+1
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= SW + 10; i++) begin
      @(posedge clk);
      #1;
      if (cvalid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic watch(input int n, output int nv);
    nv = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (cvalid) nv++;
    end
  endtask

  int lat, nv, no, vat, oat;
  logic [XW-1:0] xs;
  logic [YW-1:0] ys;
  logic [CW-1:0] cs;
  logic [BW-1:0] bexp;

  initial begin
    rst_n = 1'b0;
    hc = '0;
    vc = '0;
    px = 1'b0;
    dv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", x_out, 0);
    chk("rst_y", y_out, 0);
    chk("rst_count", count_out, 0);
    chk("rst_found", found, 0);
    chk("rst_valid", cvalid, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_bbox", bbox, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // test 1: 2x2 block
    beat(0, 0, 1'b0);
    watch(4, nv);
    chk("t1_prime_novalid", nv, 0);
    beat(10, 20, 1'b1);
    beat(11, 20, 1'b1);
    beat(50, 50, 1'b1, 1'b0);
    beat(60, 60, 1'b0);
    beat(10, 21, 1'b1);
    beat(11, 21, 1'b1);
    beat(0, 0, 1'b0);
    wait_valid(lat);
    chk("t1_lat", lat, SW + 1);
    chk("t1_count", count_out, 4);
    chk("t1_x", x_out, 10);
    chk("t1_y", y_out, 20);
    chk("t1_found", found, 1);
    @(posedge clk);
    #1;
    chk("t1_pulse", cvalid, 0);
    chk("t1_hold_x", x_out, 10);

    // test 2: single pixel
    beat(100, 50, 1'b1);
    beat(0, 0, 1'b0);
    wait_valid(lat);
    chk("t2_lat", lat, SW + 1);
    chk("t2_count", count_out, 1);
    chk("t2_x", x_out, 100);
    chk("t2_y", y_out, 50);
    chk("t2_found", found, 0);

    // test 3: empty frame skips the divider
    beat(0, 0, 1'b0);
    wait_valid(lat);
    chk("t3_lat", lat, 1);
    chk("t3_count", count_out, 0);
    chk("t3_found", found, 0);
    chk("t3_x", x_out, 100);
    chk("t3_y", y_out, 50);
    chk("t3_bbox", bbox, 0);

    // test 4: overrun
    beat(3, 4, 1'b1);
    beat(5, 6, 1'b1);
    beat(0, 0, 1'b0);
    nv = 0;
    no = 0;
    vat = -1;
    oat = -1;
    xs = '0;
    ys = '0;
    cs = '0;
    for (int i = 1; i <= SW + 8; i++) begin
      if (i == SW / 2) begin
        hc = '0;
        vc = '0;
        px = 1'b1;
        dv = 1'b1;
      end
      @(posedge clk);
      #1;
      dv = 1'b0;
      px = 1'b0;
      if (ovr) begin
        no++;
        oat = i;
      end
      if (cvalid) begin
        nv++;
        vat = i;
        xs = x_out;
        ys = y_out;
        cs = count_out;
      end
    end
    chk("t4_ovr_n", no, 1);
    chk("t4_ovr_at", oat, SW / 2);
    chk("t4_valid_n", nv, 1);
    chk("t4_valid_at", vat, SW + 1);
    chk("t4_count", cs, 2);
    chk("t4_x", xs, 4);
    chk("t4_y", ys, 5);
    // frame opened by the overrunning start keeps its (0,0) pixel
    beat(30, 40, 1'b1);
    beat(0, 0, 1'b0);
    wait_valid(lat);
    chk("t4b_lat", lat, SW + 1);
    chk("t4b_count", count_out, 2);
    chk("t4b_x", x_out, 15);
    chk("t4b_y", y_out, 20);

    // test 5: reset mid-division
    beat(200, 100, 1'b1);
    beat(0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_x", x_out, 0);
    chk("t5_y", y_out, 0);
    chk("t5_count", count_out, 0);
    chk("t5_found", found, 0);
    chk("t5_valid", cvalid, 0);
    chk("t5_bbox", bbox, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    beat(0, 0, 1'b0);
    beat(50, 60, 1'b1);
    watch(SW + 6, nv);
    chk("t5_novalid", nv, 0);
    beat(0, 0, 1'b0);
    wait_valid(lat);
    chk("t5_lat", lat, SW + 1);
    chk("t5_count2", count_out, 1);
    chk("t5_x2", x_out, 50);
    chk("t5_y2", y_out, 60);

    // test 6: far corners, bbox
    beat(5, 7, 1'b1);
    beat(300, 170, 1'b1);
    beat(0, 0, 1'b0);
    wait_valid(lat);
    chk("t6_lat", lat, SW + 1);
    chk("t6_count", count_out, 2);
    chk("t6_x", x_out, 152);
    chk("t6_y", y_out, 88);
`ifdef MASK_CENTROID_BBOX_EN
    bexp = {9'd5, 9'd300, 8'd7, 8'd170};
`else
    bexp = '0;
`endif
    chk("t6_bbox", bbox, bexp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
